mac_stream_reader: RTL and testbench

Downstream consumer of the on-chip 1K×16 sequential memory. Drives the memory's read enable, honours its single-cycle and multi-cycle read timing, and treats the incoming word stream as interleaved signed weight/activation pairs. Computes a VEC_LEN-element signed dot product and presents it on a valid/ready result port to the neuron datapath.

---
 rtl/mac_stream_reader.sv | 148 ++++++++++++++
 tb/tb_mac_stream_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_reader.sv
// mac_stream_reader
// Pulls interleaved signed weight/activation words out of the sequential
// memory (single-cycle or multi-cycle read timing) and returns their signed
// dot product on a valid/ready result port.
module mac_stream_reader #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    multi_cycle_mode,
    input  logic [1:0]              cycle_count,
    output logic                    mem_rd_en,
    input  logic [15:0]             mem_data,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    busy
);

    localparam int WORDS  = 2 * VEC_LEN;
    localparam int WCNT_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    // Read mode and wait count captured when the job is accepted
    logic        mode_q;
    logic [1:0]  wait_q;

    // Read slot and word bookkeeping
    logic [1:0]        slot_cnt;
    logic [1:0]        slot_last;
    logic [WCNT_W-1:0] word_cnt;
    logic              fire;
    logic              last_fire;

    // Capture / multiply / accumulate pipeline
    logic                    cap_valid;
    logic                    cap_odd;
    logic signed [15:0]      weight_q;
    logic signed [31:0]      product_q;
    logic                    prod_valid;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] product_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    final_accum;

    // A slot lasts one cycle in single mode, C+1 cycles in multi mode
    assign slot_last   = mode_q ? wait_q : 2'd0;
    assign fire        = (state == FETCH) && (slot_cnt == slot_last);
    assign last_fire   = fire && (word_cnt == WCNT_W'(WORDS - 1));
    assign product_ext = ACC_W'(product_q);
    assign acc_sum     = acc_q + product_ext;
    // In DRAIN the last activation is captured in the first cycle, so a valid
    // product with nothing further in capture is the final one
    assign final_accum = (state == DRAIN) && prod_valid && !cap_valid;
    assign busy        = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and control outputs
    always_comb begin
        state_next   = state;
        mem_rd_en    = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: begin
                mem_rd_en = 1'b1;
                if (last_fire) state_next = DRAIN;
            end
            DRAIN: if (final_accum) state_next = DONE;
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch read mode at job start and count read slots and fetched words
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= 1'b0;
            wait_q   <= 2'd0;
            slot_cnt <= 2'd0;
            word_cnt <= '0;
        end else if (state == IDLE) begin
            slot_cnt <= 2'd0;
            word_cnt <= '0;
            if (start) begin
                mode_q <= multi_cycle_mode;
                wait_q <= cycle_count;
            end
        end else if (state == FETCH) begin
            if (fire) begin
                slot_cnt <= 2'd0;
                word_cnt <= word_cnt + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 2'd1;
            end
        end
    end

    // Capture words one cycle after each fire, hold weights, register products
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE)) begin
            cap_valid  <= 1'b0;
            cap_odd    <= 1'b0;
            weight_q   <= '0;
            product_q  <= '0;
            prod_valid <= 1'b0;
        end else begin
            cap_valid  <= fire;
            cap_odd    <= word_cnt[0];
            prod_valid <= cap_valid && cap_odd;
            if (cap_valid && !cap_odd) weight_q <= mem_data;
            if (cap_valid && cap_odd)
                product_q <= 32'(weight_q) * 32'(signed'(mem_data));
        end
    end

    // Accumulate products (wrapping) and publish the final sum
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            result <= '0;
        end else if (state == IDLE) begin
            if (start) acc_q <= '0;
        end else begin
            if (prod_valid)  acc_q  <= acc_sum;
            if (final_accum) result <= acc_sum;
        end
    end

endmodule

// File: tb/tb_mac_stream_reader.sv
// Testbench for mac_stream_reader: sequential memory model, scoreboard of
// expected dot products, one task per scenario.
module tb_mac_stream_reader;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               multi_cycle_mode;
    logic [1:0]         cycle_count;
    logic               mem_rd_en;
    logic [15:0]        mem_data;
    logic signed [39:0] result;
    logic               result_valid;
    logic               result_ready;
    logic               busy;
    logic               rd32;
    logic signed [31:0] result32;
    logic               valid32;
    logic               busy32;

    mac_stream_reader #(.VEC_LEN(N), .ACC_W(40)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multi_cycle_mode(multi_cycle_mode), .cycle_count(cycle_count),
        .mem_rd_en(mem_rd_en), .mem_data(mem_data), .result(result),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
    );

    mac_stream_reader #(.VEC_LEN(N), .ACC_W(32)) dut32 (
        .clk(clk), .reset(reset), .start(start),
        .multi_cycle_mode(multi_cycle_mode), .cycle_count(cycle_count),
        .mem_rd_en(rd32), .mem_data(mem_data), .result(result32),
        .result_valid(valid32), .result_ready(result_ready), .busy(busy32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [39:0] exp;
        logic signed [31:0] exp32;
        logic               chk32;
        int                 valid_cyc;
    } job_t;

    job_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   hs_count = 0;
    int   rise_cyc = -1;
    logic prev_valid = 1'b0;
    int   rd_first = 0;
    int   rd_last = 0;
    int   rd_count = 0;
    int   job_t0 = 0;

    // Sequential 1Kx16 memory model: registered output, address advances
    // once per read slot
    logic [15:0] mem [0:1023];
    logic [9:0]  mem_addr;
    logic [1:0]  mem_slot;

    always @(posedge clk) begin
        if (reset) begin
            mem_addr <= '0;
            mem_slot <= '0;
            mem_data <= '0;
        end else if (mem_rd_en) begin
            if (!multi_cycle_mode || mem_slot == cycle_count) begin
                mem_data <= mem[mem_addr];
                mem_addr <= mem_addr + 10'd1;
                mem_slot <= '0;
            end else begin
                mem_slot <= mem_slot + 2'd1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: track read-enable window, result_valid rise, and check each
    // handshake against the scoreboard
    always @(negedge clk) begin : monitor
        job_t j;
        if (!reset) begin
            if (mem_rd_en) begin
                if (rd_count == 0) rd_first = cyc;
                rd_last = cyc;
                rd_count++;
            end
            if (result_valid && !prev_valid) rise_cyc = cyc;
            if (result_valid && result_ready) begin
                hs_count++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_handshake: got result %0d with no job expected", result);
                end else begin
                    j = sb.pop_front();
                    if (result !== j.exp) begin
                        bad++;
                        $display("[TB] FAIL result: got %0d expected %0d", result, j.exp);
                    end
                    total++;
                    if (rise_cyc !== j.valid_cyc) begin
                        bad++;
                        $display("[TB] FAIL valid_cycle: got %0d expected %0d", rise_cyc, j.valid_cyc);
                    end
                    if (j.chk32) begin
                        total++;
                        if (result32 !== j.exp32) begin
                            bad++;
                            $display("[TB] FAIL result32: got %0d expected %0d", result32, j.exp32);
                        end
                    end
                end
            end
        end
        prev_valid = result_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        tick();
    endtask

    function automatic longint dot_ref(input int base);
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += longint'($signed(mem[base + 2*i])) * longint'($signed(mem[base + 2*i + 1]));
        return s;
    endfunction

    task automatic load_plan();
        int d[8] = '{2, 3, -1, 5, 4, 4, -7, -2};
        for (int i = 0; i < 8; i++) mem[i] = 16'(d[i]);
    endtask

    task automatic start_job(input logic mode, input logic [1:0] c,
                             input logic signed [39:0] e,
                             input logic signed [31:0] e32, input logic chk);
        job_t j;
        int s;
        s = mode ? int'(c) + 1 : 1;
        multi_cycle_mode = mode;
        cycle_count = c;
        start = 1'b1;
        rd_count = 0;
        job_t0 = cyc;
        j.exp = e;
        j.exp32 = e32;
        j.chk32 = chk;
        j.valid_cyc = cyc + 2*N*s + 3;
        sb.push_back(j);
    endtask

    task automatic wait_hs(input int target, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (hs_count >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL handshake_timeout: got %0d handshakes expected %0d", hs_count, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        total += 4;
        if (mem_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd_en: got %b expected 0", mem_rd_en); end
        if (result !== 40'sd0) begin bad++; $display("[TB] FAIL rst_result: got %0d expected 0", result); end
        if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b expected 0", result_valid); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        reset = 1'b0;
        tick();
        tick();
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
        if (mem_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL idle_rd_en: got %b expected 0", mem_rd_en); end
    endtask

    task automatic run_timed(input logic mode, input logic [1:0] c,
                             input logic signed [39:0] e, input logic signed [31:0] e32,
                             input logic chk, input string tag);
        int s;
        int target;
        s = mode ? int'(c) + 1 : 1;
        target = hs_count + 1;
        start_job(mode, c, e, e32, chk);
        tick();
        start = 1'b0;
        wait_hs(target, 200);
        total += 5;
        if (rd_first !== job_t0 + 1) begin bad++; $display("[TB] FAIL %s rd_first: got %0d expected %0d", tag, rd_first, job_t0 + 1); end
        if (rd_last !== job_t0 + 2*N*s) begin bad++; $display("[TB] FAIL %s rd_last: got %0d expected %0d", tag, rd_last, job_t0 + 2*N*s); end
        if (rd_count !== 2*N*s) begin bad++; $display("[TB] FAIL %s rd_count: got %0d expected %0d", tag, rd_count, 2*N*s); end
        if (cyc !== job_t0 + 2*N*s + 4) begin bad++; $display("[TB] FAIL %s idle_cycle: got %0d expected %0d", tag, cyc, job_t0 + 2*N*s + 4); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL %s busy_after: got %b expected 0", tag, busy); end
    endtask

    task automatic test_single();
        do_reset();
        load_plan();
        run_timed(1'b0, 2'd0, 40'sd31, 32'sd31, 1'b1, "single");
    endtask

    task automatic test_multi();
        do_reset();
        load_plan();
        run_timed(1'b1, 2'd2, 40'sd31, 32'sd31, 1'b0, "multi_c2");
        do_reset();
        run_timed(1'b1, 2'd0, 40'sd31, 32'sd31, 1'b0, "multi_c0");
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        run_timed(1'b1, 2'd3, 40'(dot_ref(0)), 32'(dot_ref(0)), 1'b1, "multi_c3");
    endtask

    task automatic test_backpressure();
        int base;
        bit seen = 0;
        do_reset();
        load_plan();
        result_ready = 1'b0;
        base = hs_count;
        start_job(1'b0, 2'd0, 40'sd31, 32'sd31, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (result_valid) begin seen = 1; break; end
            tick();
        end
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL bp_valid_timeout: got %b expected 1", result_valid); end
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            total += 3;
            if (result !== 40'sd31) begin bad++; $display("[TB] FAIL bp_stable: got %0d expected 31", result); end
            if (result_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid: got %b expected 1", result_valid); end
            if (busy !== 1'b1) begin bad++; $display("[TB] FAIL bp_busy: got %b expected 1", busy); end
            tick();
        end
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total += 3;
        if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drop: got %b expected 0", result_valid); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_busy_after: got %b expected 0", busy); end
        if (hs_count !== base + 1) begin bad++; $display("[TB] FAIL bp_handshakes: got %0d expected %0d", hs_count, base + 1); end
        tick();
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_start_ignored: got busy %b expected 0", busy); end
        if (mem_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL bp_rd_idle: got %b expected 0", mem_rd_en); end
        if (result !== 40'sd31) begin bad++; $display("[TB] FAIL bp_result_hold: got %0d expected 31", result); end
    endtask

    task automatic test_extremes();
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 16'h8000;
        run_timed(1'b0, 2'd0, 40'sd4294967296, 32'sd0, 1'b1, "extreme");
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_plan();
        start_job(1'b0, 2'd0, 40'sd31, 32'sd31, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        total += 4;
        if (mem_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_rd_en: got %b expected 0", mem_rd_en); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid: got %b expected 0", result_valid); end
        if (result !== 40'sd0) begin bad++; $display("[TB] FAIL mid_result: got %0d expected 0", result); end
        sb.delete();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        run_timed(1'b0, 2'd0, 40'(dot_ref(0)), 32'(dot_ref(0)), 1'b1, "after_mid");
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        base = hs_count;
        start_job(1'b0, 2'd0, 40'(dot_ref(0)), 32'(dot_ref(0)), 1'b1);
        wait_hs(base + 1, 100);
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap: got busy %b expected 0", busy); end
        start_job(1'b0, 2'd0, 40'(dot_ref(8)), 32'(dot_ref(8)), 1'b1);
        wait_hs(base + 2, 100);
        start = 1'b0;
        total++;
        if (rd_count !== 2*N) begin bad++; $display("[TB] FAIL b2b_rd_count: got %0d expected %0d", rd_count, 2*N); end
        tick();
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_no_third: got busy %b expected 0", busy); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        multi_cycle_mode = 1'b0;
        cycle_count = 2'd0;
        result_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        tick();
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_extremes();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL leftover_jobs: got %0d expected 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
